onehot_scan_decoder: RTL and testbench
======================================

ONEHOT_SCAN_DECODER -- requirements
Module: onehot_scan_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 4: select width; legal range 1..6.
REQ-002 SHALL have parameter DWELL_W, default 8: width of the scan dwell count.
REQ-003 SHALL have derived localparam OUT_W = 2**SEL_W: number of one-hot outputs.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1: high = outputs active; low = all outputs zero.
REQ-007 SHALL have port mode, input, 1: 0 = direct (handshaked select), 1 = scan (auto-step).
REQ-008 SHALL have port sel_in, input, SEL_W: index requested in direct mode.
REQ-009 SHALL have port sel_valid, input, 1: sel_in is valid.
REQ-010 SHALL have port sel_ready, output, 1: block accepts sel_in this cycle.
REQ-011 SHALL have port dwell, input, DWELL_W: extra cycles each index is held in scan mode.
REQ-012 SHALL have port y, output, OUT_W: registered one-hot output.
REQ-013 SHALL have port idx, output, SEL_W: registered index currently driven on y.
REQ-014 SHALL have port wrap, output, 1: one-cycle pulse when scan steps from OUT_W-1 to 0.

Function
REQ-015 SHALL use a state machine with states IDLE, DIRECT and SCAN.
REQ-016 SHALL enter IDLE from any state on the cycle after enable is sampled low; IDLE drives y = 0 and holds idx.
REQ-017 SHALL go from IDLE to DIRECT (mode=0) or SCAN (mode=1) on the cycle after enable is sampled high.
REQ-018 SHALL switch DIRECT<->SCAN one cycle after mode changes, clearing the dwell counter and keeping idx.
REQ-019 SHALL drive sel_ready = 1 only in DIRECT with enable high; it SHALL NOT depend combinationally on sel_valid.
REQ-020 SHALL, on a handshake (sel_valid & sel_ready), load idx = sel_in and set y = 1<<sel_in in the following cycle (1-cycle latency).
REQ-021 SHALL hold idx and y in DIRECT while there is no handshake.
REQ-022 SHALL hold each index in SCAN for exactly dwell+1 cycles; dwell = 0 SHALL step every cycle.
REQ-023 SHALL sample dwell when the dwell counter restarts; mid-dwell changes SHALL apply to the next step only.
REQ-024 SHALL step idx from OUT_W-1 to 0 (modulo OUT_W) and assert wrap for exactly the cycle in which idx = 0 is first presented.
REQ-025 SHALL keep y one-hot and equal to 1<<idx in DIRECT and SCAN, and all-zero in IDLE; y SHALL NOT glitch to multi-hot on any transition.
REQ-026 SHALL give enable low priority over everything: a handshake in the same cycle enable is sampled low SHALL be discarded.
REQ-027 SHALL keep wrap low outside SCAN.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously force state = IDLE, idx = 0, y = 0, wrap = 0, sel_ready = 0 and the dwell counter = 0.
REQ-029 SHALL leave IDLE no earlier than the first rising clk edge after rst_n deasserts; releasing reset mid-scan SHALL restart the scan from idx 0.

Structure
REQ-030 SHALL place the state enum (IDLE, DIRECT, SCAN) and the mode constants MODE_DIRECT = 0 and MODE_SCAN = 1 in the shared package onehot_scan_pkg.
REQ-031 SHALL instantiate one combinational sub-module, onehot_dec (parameter SEL_W; input index, input en, output OUT_W one-hot), whose output feeds the y register.

Verification
REQ-032 SHALL cover reset: assert rst_n=0 mid-scan with SEL_W=4 -> y=0, idx=0, wrap=0 immediately, without waiting for a clk edge.
REQ-033 SHALL cover direct mode: enable=1, mode=0, sel_in=9, sel_valid=1 -> y=16'h0200 and idx=9 one cycle after the handshake.
REQ-034 SHALL cover scan timing: mode=1, dwell=2 -> idx sequence 0,0,0,1,1,1,2 and so on; after idx 15, wrap pulses once, together with idx=0 and y=16'h0001.
REQ-035 SHALL cover dwell=0: idx increments every cycle, and wrap pulses every 16 cycles.
REQ-036 SHALL cover enable drop: enable=0 on the same cycle as a handshake with sel_in=3 -> y=0 next cycle, idx unchanged, handshake discarded.
REQ-037 SHALL cover a mode change mid-dwell: switch from scan to direct at idx=5 -> idx stays 5, y=16'h0020, and sel_ready=1 on the next cycle.

Source files
------------

// File: rtl/onehot_scan_pkg.sv
// Shared types and constants for the one-hot scan decoder.
// Holds the controller state encoding and the mode input encoding.
package onehot_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index to one-hot decoder with an output enable.
// A disabled decoder drives all zeros.
module onehot_dec #(
  parameter  int SEL_W = 4,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic [SEL_W-1:0] index,
  input  logic             en,
  output logic [OUT_W-1:0] onehot
);

  // Exactly one bit set when enabled, none otherwise.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[index] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// One-hot output decoder with a handshaked direct-select mode and an
// auto-stepping scan mode; every output comes straight from a flop.
module onehot_scan_decoder
  import onehot_scan_pkg::*;
#(
  parameter  int SEL_W   = 4,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [OUT_W-1:0]     y_q, y_d;
  logic                 wrap_q, wrap_d;
  logic                 sel_ready_q, sel_ready_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   lim_q, lim_d;
  logic                 hs;

  // Enable low wins over any other request, so it is folded into the accept.
  assign hs = sel_valid & sel_ready_q & enable;

  // Next-state: enable low always parks in IDLE, otherwise mode picks the state.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DIRECT, SCAN: state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
        default:            state_d = IDLE;
      endcase
    end
  end

  // Index, dwell counter and wrap pulse; the dwell limit is latched on each restart.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    wrap_d = 1'b0;
    case (state_d)
      IDLE: begin
        cnt_d = '0;
      end
      DIRECT: begin
        cnt_d = '0;
        if (hs && (state_q == DIRECT)) begin
          idx_d = sel_in;
        end else begin
          idx_d = idx_q;
        end
      end
      SCAN: begin
        if (state_q != SCAN) begin
          cnt_d = '0;
          lim_d = dwell;
        end else if (cnt_q == lim_q) begin
          idx_d  = idx_q + SEL_W'(1);
          cnt_d  = '0;
          lim_d  = dwell;
          wrap_d = &idx_q;
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Ready tracks the registered state, never sel_valid.
  always_comb begin
    sel_ready_d = (state_d == DIRECT);
  end

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .index  (idx_d),
    .en     (state_d != IDLE),
    .onehot (y_d)
  );

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      y_q         <= '0;
      wrap_q      <= 1'b0;
      sel_ready_q <= 1'b0;
      cnt_q       <= '0;
      lim_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      y_q         <= y_d;
      wrap_q      <= wrap_d;
      sel_ready_q <= sel_ready_d;
      cnt_q       <= cnt_d;
      lim_q       <= lim_d;
    end
  end

  assign sel_ready = sel_ready_q;
  assign y         = y_q;
  assign idx       = idx_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed scoreboard bench for onehot_scan_decoder (SEL_W=4, DWELL_W=8).
module tb_onehot_scan_decoder;

  localparam int SEL_W   = 4;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 2**SEL_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               mode;
  logic [SEL_W-1:0]   sel_in;
  logic               sel_valid;
  logic               sel_ready;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  typedef struct {
    string       tag;
    logic [15:0] y;
    logic [3:0]  idx;
    logic        wrap;
    logic        rdy;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder #(
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .sel_in    (sel_in),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .dwell     (dwell),
    .y         (y),
    .idx       (idx),
    .wrap      (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] ey, input logic [3:0] eidx,
                      input logic ewrap, input logic erdy);
    exp_t e;
    e.tag  = tag;
    e.y    = ey;
    e.idx  = eidx;
    e.wrap = ewrap;
    e.rdy  = erdy;
    sbq.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.tag, ".y"},    32'(y),         32'(e.y));
      chk({e.tag, ".idx"},  32'(idx),       32'(e.idx));
      chk({e.tag, ".wrap"}, 32'(wrap),      32'(e.wrap));
      chk({e.tag, ".rdy"},  32'(sel_ready), 32'(e.rdy));
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".y"},    32'(y),         32'h0);
    chk({tag, ".idx"},  32'(idx),       32'h0);
    chk({tag, ".wrap"}, 32'(wrap),      32'h0);
    chk({tag, ".rdy"},  32'(sel_ready), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ix;
    rst_n     = 1'b0;
    enable    = 1'b0;
    mode      = 1'b0;
    sel_in    = 4'd0;
    sel_valid = 1'b0;
    dwell     = 8'd0;
    #3;
    chk_reset_outs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Direct mode: enter, handshake index 9, then hold without handshake.
    enable = 1'b1;
    mode   = 1'b0;
    push("dir_enter", 16'h0001, 4'd0, 1'b0, 1'b1);
    cycle();
    sel_in    = 4'd9;
    sel_valid = 1'b1;
    push("dir_hs9", 16'h0200, 4'd9, 1'b0, 1'b1);
    cycle();
    sel_valid = 1'b0;
    sel_in    = 4'd2;
    push("dir_hold", 16'h0200, 4'd9, 1'b0, 1'b1);
    cycle();

    // Enable drop together with a handshake on index 3: handshake is lost.
    sel_in    = 4'd3;
    sel_valid = 1'b1;
    enable    = 1'b0;
    push("en_drop", 16'h0000, 4'd9, 1'b0, 1'b0);
    cycle();
    sel_valid = 1'b0;
    push("idle_hold", 16'h0000, 4'd9, 1'b0, 1'b0);
    cycle();
    enable = 1'b1;
    push("en_back", 16'h0200, 4'd9, 1'b0, 1'b1);
    cycle();

    // Park on index 0, then scan with dwell=2 through a full wrap.
    sel_in    = 4'd0;
    sel_valid = 1'b1;
    push("dir_hs0", 16'h0001, 4'd0, 1'b0, 1'b1);
    cycle();
    sel_valid = 1'b0;
    mode      = 1'b1;
    dwell     = 8'd2;
    for (int k = 0; k < 51; k++) begin
      ix = (k / 3) % 16;
      push($sformatf("scan_d2_k%0d", k), 16'h0001 << ix, 4'(ix), 1'(k == 48), 1'b0);
      cycle();
    end

    // dwell=0: the pending step finishes, then one step per cycle.
    dwell = 8'd0;
    for (int j = 0; j < 34; j++) begin
      ix = (1 + j) % 16;
      push($sformatf("scan_d0_j%0d", j), 16'h0001 << ix, 4'(ix), 1'(ix == 0), 1'b0);
      cycle();
    end

    // dwell=3, then leave scan mid-dwell while idx=5.
    dwell = 8'd3;
    for (int m = 0; m < 10; m++) begin
      ix = 3 + m / 4;
      push($sformatf("scan_d3_m%0d", m), 16'h0001 << ix, 4'(ix), 1'b0, 1'b0);
      cycle();
    end
    mode = 1'b0;
    push("to_direct", 16'h0020, 4'd5, 1'b0, 1'b1);
    cycle();

    // Back into scan, then assert reset between clock edges.
    mode  = 1'b1;
    dwell = 8'd0;
    push("to_scan", 16'h0020, 4'd5, 1'b0, 1'b0);
    cycle();
    push("scan_step6", 16'h0040, 4'd6, 1'b0, 1'b0);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    @(posedge clk);
    #1;
    chk_reset_outs("rst_held");
    rst_n = 1'b1;
    push("rst_restart0", 16'h0001, 4'd0, 1'b0, 1'b0);
    cycle();
    push("rst_restart1", 16'h0002, 4'd1, 1'b0, 1'b0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
